dram_cmd_sched: RTL and testbench

DRAM_CMD_SCHED -- requirements
Module: dram_cmd_sched

---
 rtl/dram_ctrl_pkg.sv | 31 +++
 rtl/dram_open_row_tbl.sv | 61 ++++++
 rtl/dram_cmd_sched.sv | 238 +++++++++++++++++++++++
 tb/tb_dram_cmd_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the DRAM command scheduler: FSM state encoding,
// default timing values and a small elaboration-time helper.
package dram_ctrl_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ACT  = 3'd2,
        RD   = 3'd3,
        RDW  = 3'd4,
        RCAP = 3'd5,
        WR   = 3'd6,
        REF  = 3'd7
    } sched_state_t;

    // Default array geometry and timing.
    localparam int DEF_NUM_OF_BANKS = 8;
    localparam int DEF_NUM_OF_ROWS  = 128;
    localparam int DEF_NUM_OF_COLS  = 8;
    localparam int DEF_DATA_WIDTH   = 1;
    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_REFI       = 512;

    // Larger of two integers, used to size the shared wait timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_open_row_tbl.sv
// Per-bank open-row bookkeeping. Each bank keeps an open flag and the row
// that is currently open. A combinational lookup classifies an incoming
// (bank,row) pair as hit, closed or conflict. Updates: set one bank open at
// a row, clear one bank, or clear every bank (refresh / reset).
module dram_open_row_tbl
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS
) (
    input  logic                            clk,
    input  logic                            rst_b,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] lk_bank_i,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  lk_row_i,
    output logic                            lk_hit_o,
    output logic                            lk_closed_o,
    output logic                            lk_conflict_o,
    input  logic                            set_en_i,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] set_bank_i,
    input  logic [$clog2(NUM_OF_ROWS)-1:0]  set_row_i,
    input  logic                            clr_en_i,
    input  logic [$clog2(NUM_OF_BANKS)-1:0] clr_bank_i,
    input  logic                            clr_all_i
);

    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);

    logic [NUM_OF_BANKS-1:0] open_q;
    logic [RW-1:0]           row_q [NUM_OF_BANKS];

    logic          sel_open;
    logic [RW-1:0] sel_row;

    generate
        for (genvar gi = 0; gi < NUM_OF_BANKS; gi++) begin : g_bank
            // Per-bank open flag and row; clearing takes precedence over setting.
            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    open_q[gi] <= 1'b0;
                    row_q[gi]  <= '0;
                end else if (clr_all_i || (clr_en_i && (clr_bank_i == BW'(gi)))) begin
                    open_q[gi] <= 1'b0;
                end else if (set_en_i && (set_bank_i == BW'(gi))) begin
                    open_q[gi] <= 1'b1;
                    row_q[gi]  <= set_row_i;
                end
            end
        end
    endgenerate

    // Classify the looked-up bank against its open row.
    always_comb begin
        sel_open      = open_q[lk_bank_i];
        sel_row       = row_q[lk_bank_i];
        lk_hit_o      = sel_open && (sel_row == lk_row_i);
        lk_closed_o   = !sel_open;
        lk_conflict_o = sel_open && (sel_row != lk_row_i);
    end

endmodule

// File: rtl/dram_cmd_sched.sv
// DRAM command scheduler: accepts one read/write request at a time, opens
// the target row (precharging a conflicting row first), issues the array
// command and returns read data. Outputs bank_rw/buffer_rw decode directly
// from the FSM state so they can never be active together.
// Optional periodic refresh is compiled in with DRAM_CMD_SCHED_REFRESH_EN;
// without it rows stay open until a conflicting access and ref_busy is 0.
module dram_cmd_sched
    import dram_ctrl_pkg::*;
#(
    parameter int NUM_OF_BANKS = DEF_NUM_OF_BANKS,
    parameter int NUM_OF_ROWS  = DEF_NUM_OF_ROWS,
    parameter int NUM_OF_COLS  = DEF_NUM_OF_COLS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_REFI       = DEF_T_REFI
) (
    input  logic                                                              clk,
    input  logic                                                              rst_b,
    input  logic                                                              req_valid,
    output logic                                                              req_ready,
    input  logic                                                              req_we,
    input  logic [$clog2(NUM_OF_BANKS)+$clog2(NUM_OF_ROWS)+$clog2(NUM_OF_COLS)-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]                                             req_wdata,
    output logic                                                              rsp_valid,
    output logic [DATA_WIDTH-1:0]                                             rsp_rdata,
    output logic                                                              bank_rw,
    output logic                                                              buffer_rw,
    output logic [$clog2(NUM_OF_BANKS)-1:0]                                   bank_id,
    output logic [$clog2(NUM_OF_ROWS)-1:0]                                    rowid,
    output logic [$clog2(NUM_OF_COLS)-1:0]                                    colid,
    output logic [DATA_WIDTH-1:0]                                             din,
    input  logic [DATA_WIDTH-1:0]                                             dout,
    output logic                                                              ref_busy
);

    localparam int BW = $clog2(NUM_OF_BANKS);
    localparam int RW = $clog2(NUM_OF_ROWS);
    localparam int CW = $clog2(NUM_OF_COLS);
    localparam int AW = BW + RW + CW;
    // Shared down-counter for the PRE/ACT/REF waits.
    localparam int TW = $clog2(max_int(T_RCD, T_RP) + 1);

    sched_state_t state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;

    logic                  we_q;
    logic [BW-1:0]         bank_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic accept;
    logic ref_go;
    logic set_en;
    logic clr_en;
    logic clr_all;
    logic lk_hit;
    logic lk_closed;
    logic lk_conflict;

    logic [BW-1:0] req_bank;
    logic [RW-1:0] req_row;

    assign req_bank = req_addr[AW-1 -: BW];
    assign req_row  = req_addr[CW +: RW];

    dram_open_row_tbl #(
        .NUM_OF_BANKS (NUM_OF_BANKS),
        .NUM_OF_ROWS  (NUM_OF_ROWS)
    ) u_open_row_tbl (
        .clk           (clk),
        .rst_b         (rst_b),
        .lk_bank_i     (req_bank),
        .lk_row_i      (req_row),
        .lk_hit_o      (lk_hit),
        .lk_closed_o   (lk_closed),
        .lk_conflict_o (lk_conflict),
        .set_en_i      (set_en),
        .set_bank_i    (bank_q),
        .set_row_i     (row_q),
        .clr_en_i      (clr_en),
        .clr_bank_i    (bank_q),
        .clr_all_i     (clr_all)
    );

`ifdef DRAM_CMD_SCHED_REFRESH_EN
    localparam int FW = (T_REFI > 1) ? $clog2(T_REFI) : 1;

    logic [FW-1:0] ref_cnt_q;
    logic          ref_pend_q;
    logic          ref_wrap;
    logic          ref_done;

    assign ref_wrap = (ref_cnt_q == FW'(T_REFI - 1));
    assign ref_done = (state_q == REF) && (tmr_q == '0);
    // The wrap cycle itself already blocks new requests so refresh wins ties.
    assign ref_go   = ref_pend_q || ref_wrap;
    assign ref_busy = (state_q == REF);

    // Free-running refresh interval counter with a single pending flag;
    // finishing a refresh clears the flag even if a wrap lands on that cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + 1'b1;
            if (ref_done) begin
                ref_pend_q <= 1'b0;
            end else if (ref_wrap) begin
                ref_pend_q <= 1'b1;
            end
        end
    end
`else
    assign ref_go   = 1'b0;
    assign ref_busy = 1'b0;
`endif

    assign req_ready = (state_q == IDLE) && !ref_go;
    assign accept    = req_valid && req_ready;

    // Next-state logic and open-row table update strobes.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        set_en  = 1'b0;
        clr_en  = 1'b0;
        clr_all = 1'b0;
        case (state_q)
            IDLE: begin
                if (ref_go) begin
                    state_d = REF;
                    tmr_d   = TW'(T_RP - 1);
                end else if (accept) begin
                    if (lk_hit) begin
                        state_d = req_we ? WR : RD;
                    end else if (lk_closed) begin
                        state_d = ACT;
                        tmr_d   = TW'(T_RCD - 1);
                    end else if (lk_conflict) begin
                        state_d = PRE;
                        tmr_d   = TW'(T_RP - 1);
                    end
                end
            end
            PRE: begin
                if (tmr_q == '0) begin
                    clr_en  = 1'b1;
                    state_d = ACT;
                    tmr_d   = TW'(T_RCD - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ACT: begin
                if (tmr_q == '0) begin
                    set_en  = 1'b1;
                    state_d = we_q ? WR : RD;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RD:   state_d = RDW;
            RDW:  state_d = RCAP;
            RCAP: state_d = IDLE;
            WR:   state_d = IDLE;
            REF: begin
`ifdef DRAM_CMD_SCHED_REFRESH_EN
                if (tmr_q == '0) begin
                    clr_all = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and wait timer.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // Request fields are captured only on an accepted handshake and then held
    // so the command bus keeps showing the last addressed location.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            we_q    <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            bank_q  <= req_addr[AW-1 -: BW];
            row_q   <= req_addr[CW +: RW];
            col_q   <= req_addr[CW-1:0];
            wdata_q <= req_wdata;
        end
    end

    // Read capture: dout is registered in RCAP and flagged valid one cycle later.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= (state_q == RCAP);
            if (state_q == RCAP) begin
                rsp_rdata_q <= dout;
            end
        end
    end

    assign bank_rw   = (state_q == WR);
    assign buffer_rw = (state_q == RD);
    assign bank_id   = bank_q;
    assign rowid     = row_q;
    assign colid     = col_q;
    assign din       = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Testbench for dram_cmd_sched: a behavioural array model answers the command
// bus, and a reference model (open-row table + expected memory) predicts
// response latency and data. Refresh scenario runs only with
// DRAM_CMD_SCHED_REFRESH_EN defined.
module tb_dram_cmd_sched;

    localparam int NB    = 8;
    localparam int NR    = 128;
    localparam int NC    = 8;
    localparam int DW    = 1;
    localparam int TRCD  = 2;
    localparam int TRP   = 2;
`ifdef DRAM_CMD_SCHED_REFRESH_EN
    localparam int TREFI = 16;
`else
    localparam int TREFI = 512;
`endif
    localparam int BW = $clog2(NB);
    localparam int RW = $clog2(NR);
    localparam int CW = $clog2(NC);
    localparam int AW = BW + RW + CW;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          bank_rw;
    logic          buffer_rw;
    logic [BW-1:0] bank_id;
    logic [RW-1:0] rowid;
    logic [CW-1:0] colid;
    logic [DW-1:0] din;
    logic [DW-1:0] dout = '0;
    logic          ref_busy;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int excl_viol = 0;
    int txn_no = 0;

    logic [DW-1:0] arr_mem [NB*NR*NC];
    logic [DW-1:0] exp_mem [NB*NR*NC];
    bit            m_open [NB];
    int            m_row  [NB];

    dram_cmd_sched #(
        .NUM_OF_BANKS (NB),
        .NUM_OF_ROWS  (NR),
        .NUM_OF_COLS  (NC),
        .DATA_WIDTH   (DW),
        .T_RCD        (TRCD),
        .T_RP         (TRP),
        .T_REFI       (TREFI)
    ) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bank_rw   (bank_rw),
        .buffer_rw (buffer_rw),
        .bank_id   (bank_id),
        .rowid     (rowid),
        .colid     (colid),
        .din       (din),
        .dout      (dout),
        .ref_busy  (ref_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural array: write on bank_rw, read into the sense buffer on buffer_rw.
    always @(posedge clk) begin
        if (bank_rw) arr_mem[{bank_id, rowid, colid}] <= din;
        if (buffer_rw) dout <= arr_mem[{bank_id, rowid, colid}];
    end

    always @(negedge clk) begin
        if (rst_b && bank_rw && buffer_rw) excl_viol <= excl_viol + 1;
    end

    function automatic logic [AW-1:0] mk_addr(input int b, input int r, input int c);
        return AW'((b << (RW + CW)) | (r << CW) | c);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = 0;
        end
    endtask

    // One request from issue to completion, checked against the reference model.
    task automatic do_txn(input bit we, input int b, input int r, input int c,
                          input logic [DW-1:0] wd);
        int idx, lat_exp, t, acc, at, kind;
        bit seen;
        logic [DW-1:0] exp_rd;
        idx  = b * NR * NC + r * NC + c;
        kind = (m_open[b] && m_row[b] == r) ? 0 : (!m_open[b] ? 1 : 2);
        lat_exp = (we ? 1 : 4) + ((kind == 1) ? TRCD : (kind == 2) ? (TRP + TRCD) : 0);
        m_open[b] = 1'b1;
        m_row[b]  = r;
        if (we) exp_mem[idx] = wd;
        exp_rd = exp_mem[idx];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = mk_addr(b, r, c);
        req_wdata = wd;
        t = 0;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, t);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        at = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            if (we ? bank_rw : rsp_valid) begin
                seen = 1'b1;
                at = cyc - acc;
            end else begin
                @(negedge clk);
            end
        end
        n_chk++;
        if (!seen) begin
            $display("FAIL cmd_timeout: %s event not seen, required within 60 cycles", we ? "bank_rw" : "rsp_valid");
            return;
        end
        n_pass++;
`ifndef DRAM_CMD_SCHED_REFRESH_EN
        n_chk++;
        if (at !== lat_exp) $display("FAIL latency: got A+%0d, required A+%0d (b=%0d r=%0d)", at, lat_exp, b, r);
        else n_pass++;
`endif
        if (we) begin
            n_chk++;
            if (bank_id !== BW'(b) || rowid !== RW'(r) || colid !== CW'(c) || din !== wd)
                $display("FAIL wr_fields: got b=%0d r=%0d c=%0d d=%0h, required b=%0d r=%0d c=%0d d=%0h",
                         bank_id, rowid, colid, din, b, r, c, wd);
            else n_pass++;
        end else begin
            n_chk++;
            if (rsp_rdata !== exp_rd) $display("FAIL rd_data: got %0h, required %0h (b=%0d r=%0d c=%0d)", rsp_rdata, exp_rd, b, r, c);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if ((we ? bank_rw : rsp_valid) !== 1'b0) $display("FAIL one_cycle_pulse: got 1 on second cycle, required 0");
        else n_pass++;
        $display("txn %0d: %s b=%0d r=%0d c=%0d d=%0h kind=%0d lat=%0d", txn_no, we ? "WR" : "RD", b, r, c,
                 we ? wd : rsp_rdata, kind, at);
        txn_no++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_b = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (bank_rw !== 1'b0)   $display("FAIL rst_bank_rw: got %0b, required 0", bank_rw);     else n_pass++;
        n_chk++; if (buffer_rw !== 1'b0) $display("FAIL rst_buffer_rw: got %0b, required 0", buffer_rw); else n_pass++;
        n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %0b, required 0", rsp_valid); else n_pass++;
        n_chk++; if (rsp_rdata !== '0)   $display("FAIL rst_rsp_rdata: got %0h, required 0", rsp_rdata); else n_pass++;
        n_chk++; if (bank_id !== '0 || rowid !== '0 || colid !== '0)
            $display("FAIL rst_addr: got %0d/%0d/%0d, required 0/0/0", bank_id, rowid, colid); else n_pass++;
        n_chk++; if (din !== '0)         $display("FAIL rst_din: got %0h, required 0", din);             else n_pass++;
        n_chk++; if (ref_busy !== 1'b0)  $display("FAIL rst_ref_busy: got %0b, required 0", ref_busy);   else n_pass++;
        rst_b = 1'b1;
        @(negedge clk);
        n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %0b, required 1", req_ready); else n_pass++;
    endtask

    task automatic test_write_read();
        do_txn(1'b1, 3, 5, 2, 1'b1);
        do_txn(1'b0, 3, 5, 2, 1'b0);
    endtask

    task automatic test_conflict();
        do_txn(1'b0, 3, 9, 2, 1'b0);
        do_txn(1'b0, 3, 9, 2, 1'b0);
        do_txn(1'b0, 3, 5, 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int t, acc1, acc2;
        do_txn(1'b1, 6, 9, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = mk_addr(6, 9, 1); req_wdata = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        acc1 = cyc;
        @(negedge clk);
        req_addr = mk_addr(6, 9, 4); req_wdata = 1'b0;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL b2b_ready_busy: got %0b, required 0", req_ready); else n_pass++;
        n_chk++; if (bank_rw !== 1'b1 || colid !== CW'(1) || din !== 1'b1)
            $display("FAIL b2b_first_cmd: got bank_rw=%0b col=%0d d=%0h, required 1/1/1", bank_rw, colid, din); else n_pass++;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        acc2 = cyc;
`ifndef DRAM_CMD_SCHED_REFRESH_EN
        n_chk++; if (acc2 - acc1 !== 2) $display("FAIL b2b_accept: got A+%0d, required A+2", acc2 - acc1); else n_pass++;
`endif
        @(negedge clk);
        req_valid = 1'b0;
        n_chk++; if (bank_rw !== 1'b1 || colid !== CW'(4) || din !== 1'b0)
            $display("FAIL b2b_second_cmd: got bank_rw=%0b col=%0d d=%0h, required 1/4/0", bank_rw, colid, din); else n_pass++;
        exp_mem[6 * NR * NC + 9 * NC + 1] = 1'b1;
        exp_mem[6 * NR * NC + 9 * NC + 4] = 1'b0;
        $display("txn %0d: b2b WR b=6 r=9 c=1 then c=4 accepted %0d apart", txn_no, acc2 - acc1);
        txn_no++;
        do_txn(1'b0, 6, 9, 1, 1'b0);
    endtask

    task automatic test_reset_abort();
        int t, bad;
        do_txn(1'b1, 2, 7, 0, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = mk_addr(5, 1, 3); req_wdata = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0;
        rst_b = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 2) rst_b = 1'b1;
            if (bank_rw || buffer_rw || rsp_valid) bad++;
            @(negedge clk);
        end
        n_chk++; if (bad !== 0) $display("FAIL abort_cmds: got %0d command cycles, required 0", bad); else n_pass++;
        clear_model();
        do_txn(1'b0, 2, 7, 0, 1'b0);
        do_txn(1'b0, 5, 1, 3, 1'b0);
    endtask

    task automatic test_random();
        int b, r, c;
        bit we;
        for (int n = 0; n < 40; n++) begin
            b  = $urandom_range(0, NB - 1);
            r  = $urandom_range(0, 3);
            c  = $urandom_range(0, NC - 1);
            we = $urandom_range(0, 1);
            do_txn(we, b, r, c, DW'($urandom));
        end
    endtask

`ifdef DRAM_CMD_SCHED_REFRESH_EN
    task automatic test_refresh();
        int t, rc, busy_n, acc, at;
        apply_reset();
        rst_b = 1'b1;
        t = 0;
        while (!ref_busy && t < TREFI + 10) begin @(negedge clk); t++; end
        n_chk++; if (ref_busy !== 1'b1) $display("FAIL ref_first: got ref_busy=%0b, required 1", ref_busy); else n_pass++;
        rc = cyc;
        clear_model();
        do_txn(1'b1, 4, 2, 3, 1'b1);
        t = 0;
        while (cyc < rc + TREFI - 1 && t < 40) begin @(negedge clk); t++; end
        n_chk++; if (cyc !== rc + TREFI - 1) $display("FAIL ref_phase: got cycle %0d, required %0d", cyc, rc + TREFI - 1); else n_pass++;
        req_valid = 1'b1; req_we = 1'b0; req_addr = mk_addr(4, 2, 3); req_wdata = 1'b0;
        n_chk++; if (req_ready !== 1'b0) $display("FAIL ref_defer: got req_ready=%0b at wrap, required 0", req_ready); else n_pass++;
        busy_n = 0;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            if (ref_busy) busy_n++;
            @(negedge clk);
            t++;
        end
        acc = cyc;
        n_chk++; if (busy_n !== TRP) $display("FAIL ref_busy_len: got %0d, required %0d", busy_n, TRP); else n_pass++;
        n_chk++; if (acc - rc !== TREFI + TRP) $display("FAIL ref_accept: got R+%0d, required R+%0d", acc - rc, TREFI + TRP); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
        at = cyc - acc;
        n_chk++; if (at !== 4 + TRCD) $display("FAIL ref_miss_latency: got A+%0d, required A+%0d", at, 4 + TRCD); else n_pass++;
        n_chk++; if (rsp_rdata !== 1'b1) $display("FAIL ref_rd_data: got %0h, required 1", rsp_rdata); else n_pass++;
        $display("txn %0d: refresh-deferred RD b=4 r=2 c=3 lat=%0d", txn_no, at);
        txn_no++;
    endtask
`endif

    initial begin
        for (int i = 0; i < NB * NR * NC; i++) begin
            arr_mem[i] = '0;
            exp_mem[i] = '0;
        end
        clear_model();
        test_reset();
        test_write_read();
        test_conflict();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef DRAM_CMD_SCHED_REFRESH_EN
        test_refresh();
`endif
        n_chk++;
        if (excl_viol !== 0) $display("FAIL exclusive_cmds: got %0d overlap cycles, required 0", excl_viol);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
